// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the sequenced add/sub ALU: op codes, controller states and the
// pass-counter width helper.
package alu_seq_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_ITER = 2'b10,
      S_DONE = 2'b11
   } state_e;

   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Operand/control front-end to result back-end bus of the sequenced ALU.
// master drives the request, slave (the ALU) returns status and results.
interface alu_seq_ctrl_if #(parameter int WIDTH = 4);

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] res_lo;
   logic [WIDTH-1:0] res_hi;
   logic             carry;
   logic             zf;
   logic             of;
   logic             dz;

   modport master (
      output start, op, a, b,
      input  busy, done, res_lo, res_hi, carry, zf, of, dz
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, res_lo, res_hi, carry, zf, of, dz
   );

endinterface

// File: rtl/alu_seq_ctrl_addsub.sv
// The one shared WIDTH-bit add/sub unit: ctl=0 gives x+y, ctl=1 gives x+~y+1.
// cout is bit WIDTH of that sum (carry-out for add, no-borrow for subtract).
module addsub_unit #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             ctl,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] y_s;
   logic [WIDTH:0]   full_s;

   // Two's-complement subtract through the same adder
   always_comb begin
      if (ctl) begin
         y_s = ~y;
      end else begin
         y_s = y;
      end
      full_s = {1'b0, x} + {1'b0, y_s} + {{WIDTH{1'b0}}, ctl};
   end

   assign sum  = full_s[WIDTH-1:0];
   assign cout = full_s[WIDTH];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer that turns one add/sub unit into ADD/SUB/MUL(shift-add)/DIV(restoring).
// Define ALU_DIV_EN to build the divider; otherwise op=11 reports dz as "unsupported".
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_ctrl_if.slave bus
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state_r;
   op_e              op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic [CNT_W-1:0] cnt_r;

   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] res_lo_r;
   logic [WIDTH-1:0] res_hi_r;
   logic             carry_r;
   logic             zf_r;
   logic             of_r;
   logic             dz_r;

   logic [WIDTH-1:0] x_s;
   logic [WIDTH-1:0] y_s;
   logic             ctl_s;
   logic [WIDTH-1:0] sum_s;
   logic             cout_s;
   logic             of_s;
   logic [WIDTH-1:0] mul_sum_s;
   logic             mul_c_s;
   logic [WIDTH-1:0] mul_hi_s;
   logic [WIDTH-1:0] mul_lo_s;

   addsub_unit #(.WIDTH(WIDTH)) u_addsub (
      .x    (x_s),
      .y    (y_s),
      .ctl  (ctl_s),
      .sum  (sum_s),
      .cout (cout_s)
   );

`ifdef ALU_DIV_EN
   // rem only ever needs WIDTH bits between passes: a restoring step leaves rem < b.
   logic [WIDTH:0]   rem_sh_s;
   logic [WIDTH-1:0] div_rem_s;
   logic [WIDTH-1:0] div_q_s;

   assign rem_sh_s = {hi_r, lo_r[WIDTH-1]};

   // One restoring-divide pass: keep the trial difference when it does not borrow
   always_comb begin
      if (rem_sh_s[WIDTH] | cout_s) begin
         div_rem_s = sum_s;
         div_q_s   = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
         div_rem_s = rem_sh_s[WIDTH-1:0];
         div_q_s   = {lo_r[WIDTH-2:0], 1'b0};
      end
   end
`endif

   // Operand mux for the shared unit, chosen by state and operation
   always_comb begin
      x_s   = a_r;
      y_s   = b_r;
      ctl_s = (op_r == OP_SUB);
      if (state_r == S_ITER) begin
         case (op_r)
            OP_MUL: begin
               x_s   = hi_r;
               y_s   = a_r;
               ctl_s = 1'b0;
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
               x_s   = rem_sh_s[WIDTH-1:0];
               y_s   = b_r;
               ctl_s = 1'b1;
            end
`endif
            default: begin
               x_s   = a_r;
               y_s   = b_r;
               ctl_s = 1'b0;
            end
         endcase
      end else begin
         ctl_s = (op_r == OP_SUB);
      end
   end

   // Signed overflow and one shift-add multiply pass
   always_comb begin
      if (op_r == OP_SUB) begin
         of_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
      end else begin
         of_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      if (lo_r[0]) begin
         mul_sum_s = sum_s;
         mul_c_s   = cout_s;
      end else begin
         mul_sum_s = hi_r;
         mul_c_s   = 1'b0;
      end
      mul_hi_s = {mul_c_s, mul_sum_s[WIDTH-1:1]};
      mul_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
   end

   // Controller FSM with registered status and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= S_IDLE;
         op_r     <= OP_ADD;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         hi_r     <= {WIDTH{1'b0}};
         lo_r     <= {WIDTH{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         res_lo_r <= {WIDTH{1'b0}};
         res_hi_r <= {WIDTH{1'b0}};
         carry_r  <= 1'b0;
         zf_r     <= 1'b0;
         of_r     <= 1'b0;
         dz_r     <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (bus.start) begin
                  op_r   <= op_e'(bus.op);
                  a_r    <= bus.a;
                  b_r    <= bus.b;
                  busy_r <= 1'b1;
                  dz_r   <= 1'b0;
                  cnt_r  <= {CNT_W{1'b0}};
                  case (op_e'(bus.op))
                     OP_MUL: begin
                        hi_r    <= {WIDTH{1'b0}};
                        lo_r    <= bus.b;
                        state_r <= S_ITER;
                     end
`ifdef ALU_DIV_EN
                     OP_DIV: begin
                        hi_r    <= {WIDTH{1'b0}};
                        lo_r    <= bus.a;
                        state_r <= (bus.b == {WIDTH{1'b0}}) ? S_EXEC : S_ITER;
                     end
`endif
                     default: begin
                        state_r <= S_EXEC;
                     end
                  endcase
               end
            end
            S_EXEC: begin
               state_r <= S_DONE;
               done_r  <= 1'b1;
               carry_r <= 1'b0;
               zf_r    <= 1'b0;
               of_r    <= 1'b0;
               case (op_r)
                  OP_ADD, OP_SUB: begin
                     res_lo_r <= sum_s;
                     res_hi_r <= {WIDTH{1'b0}};
                     carry_r  <= cout_s;
                     zf_r     <= (sum_s == {WIDTH{1'b0}});
                     of_r     <= of_s;
                  end
                  OP_DIV: begin
`ifdef ALU_DIV_EN
                     res_lo_r <= {WIDTH{1'b1}};
                     res_hi_r <= a_r;
`else
                     res_lo_r <= {WIDTH{1'b0}};
                     res_hi_r <= {WIDTH{1'b0}};
`endif
                     dz_r     <= 1'b1;
                  end
                  default: begin
                     res_lo_r <= {WIDTH{1'b0}};
                     res_hi_r <= {WIDTH{1'b0}};
                  end
               endcase
            end
            S_ITER: begin
               if (cnt_r == LAST_CNT) begin
                  cnt_r   <= {CNT_W{1'b0}};
                  state_r <= S_DONE;
                  done_r  <= 1'b1;
                  of_r    <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
               case (op_r)
                  OP_MUL: begin
                     hi_r <= mul_hi_s;
                     lo_r <= mul_lo_s;
                     if (cnt_r == LAST_CNT) begin
                        res_lo_r <= mul_lo_s;
                        res_hi_r <= mul_hi_s;
                        carry_r  <= (mul_hi_s != {WIDTH{1'b0}});
                        zf_r     <= ({mul_hi_s, mul_lo_s} == {(2 * WIDTH){1'b0}});
                     end
                  end
`ifdef ALU_DIV_EN
                  OP_DIV: begin
                     hi_r <= div_rem_s;
                     lo_r <= div_q_s;
                     if (cnt_r == LAST_CNT) begin
                        res_lo_r <= div_q_s;
                        res_hi_r <= div_rem_s;
                        carry_r  <= 1'b0;
                        zf_r     <= (div_q_s == {WIDTH{1'b0}});
                     end
                  end
`endif
                  default: begin
                     hi_r <= hi_r;
                  end
               endcase
            end
            S_DONE: begin
               state_r <= S_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= S_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.res_lo = res_lo_r;
   assign bus.res_hi = res_hi_r;
   assign bus.carry  = carry_r;
   assign bus.zf     = zf_r;
   assign bus.of     = of_r;
   assign bus.dz     = dz_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl against a transaction-level arithmetic model,
// plus directed cases with literal expectations (honours ALU_DIV_EN like the RTL).
module tb_alu_seq_ctrl;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         c;
      logic         z;
      logic         o;
      logic         d;
   } res_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_seq_ctrl_if #(.WIDTH(W)) bus ();

   alu_seq_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result of an operation computed with plain integer arithmetic
   function automatic res_t ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t r;
      int ua, ub, sa, sb, s, p;
      ua = int'(a);
      ub = int'(b);
      sa = a[W-1] ? ua - (1 << W) : ua;
      sb = b[W-1] ? ub - (1 << W) : ub;
      r = '0;
      case (op)
         2'd0: begin
            s = ua + ub;
            r.lo = W'(s);
            r.c = (s >= (1 << W));
            r.o = ((sa + sb) > ((1 << (W-1)) - 1)) || ((sa + sb) < -(1 << (W-1)));
            r.z = (r.lo == 0);
         end
         2'd1: begin
            r.lo = W'(ua - ub);
            r.c = (ua >= ub);
            r.o = ((sa - sb) > ((1 << (W-1)) - 1)) || ((sa - sb) < -(1 << (W-1)));
            r.z = (r.lo == 0);
         end
         2'd2: begin
            p = ua * ub;
            r.lo = W'(p);
            r.hi = W'(p >> W);
            r.c = (r.hi != 0);
            r.z = (p == 0);
         end
         default: begin
`ifdef ALU_DIV_EN
            if (ub == 0) begin
               r.lo = {W{1'b1}};
               r.hi = a;
               r.d = 1'b1;
            end else begin
               r.lo = W'(ua / ub);
               r.hi = W'(ua % ub);
               r.z = (r.lo == 0);
            end
`else
            r.d = 1'b1;
`endif
         end
      endcase
      return r;
   endfunction

   // Edges from acceptance to the done cycle
   function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] b);
      if (op == 2'd2) return W;
`ifdef ALU_DIV_EN
      if (op == 2'd3 && b != 0) return W;
`endif
      return 1;
   endfunction

   // Transaction model: accept when idle, count down latency, one-cycle done, then idle
   logic m_busy, m_done;
   int   m_pend;
   res_t m_next, m_out;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_pend <= 0;
         m_out  <= '0;
         m_next <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
         m_busy <= 1'b0;
      end else if (m_busy) begin
         m_pend <= m_pend - 1;
         if (m_pend == 1) begin
            m_done <= 1'b1;
            m_out  <= m_next;
         end
      end else if (bus.start) begin
         m_next   <= ref_op(bus.op, bus.a, bus.b);
         m_pend   <= ref_lat(bus.op, bus.b);
         m_busy   <= 1'b1;
         m_out.d  <= 1'b0;
      end
   end

   // Compare every output against the model away from the active edge
   always @(negedge clk) begin
      chk("busy",   8'(bus.busy),   8'(m_busy));
      chk("done",   8'(bus.done),   8'(m_done));
      chk("res_lo", 8'(bus.res_lo), 8'(m_out.lo));
      chk("res_hi", 8'(bus.res_hi), 8'(m_out.hi));
      chk("carry",  8'(bus.carry),  8'(m_out.c));
      chk("zf",     8'(bus.zf),     8'(m_out.z));
      chk("of",     8'(bus.of),     8'(m_out.o));
      chk("dz",     8'(bus.dz),     8'(m_out.d));
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.busy) chk("idle_timeout", 8'(bus.busy), 8'd0);
   endtask

   // Directed op: start in cycle 0, expect done in cycle exp_cyc with literal results
   task automatic do_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_cyc, input logic [W-1:0] elo,
                        input logic [W-1:0] ehi, input logic ec, input logic ez,
                        input logic eo, input logic ed);
      int n;
      wait_idle();
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 1;
      while (!bus.done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_cycle"}, 8'(n), 8'(exp_cyc));
      chk({name, "_lo"}, 8'(bus.res_lo), 8'(elo));
      chk({name, "_hi"}, 8'(bus.res_hi), 8'(ehi));
      chk({name, "_flags"}, {4'd0, bus.carry, bus.zf, bus.of, bus.dz}, {4'd0, ec, ez, eo, ed});
   endtask

   initial begin
      int pulses, done_cyc;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 8'(bus.busy), 8'd0);
      chk("rst_outs", {bus.done, bus.carry, bus.zf, bus.of, bus.dz, 3'd0}, 8'd0);
      chk("rst_res", {bus.res_hi, bus.res_lo}, 8'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op("add7_1",  2'd0, 4'd7,  4'd1,  2, 4'd8,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0);
      do_op("sub3_3",  2'd1, 4'd3,  4'd3,  2, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b0);
      do_op("sub2_5",  2'd1, 4'd2,  4'd5,  2, 4'd13, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0);
      do_op("mul15",   2'd2, 4'd15, 4'd15, 5, 4'd1,  4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
      do_op("mul0_9",  2'd2, 4'd0,  4'd9,  5, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ALU_DIV_EN
      do_op("div13_4", 2'd3, 4'd13, 4'd4,  5, 4'd3,  4'd1,  1'b0, 1'b0, 1'b0, 1'b0);
      do_op("div5_0",  2'd3, 4'd5,  4'd0,  2, 4'd15, 4'd5,  1'b0, 1'b0, 1'b0, 1'b1);
`else
      do_op("div13_4", 2'd3, 4'd13, 4'd4,  2, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1);
      do_op("div5_0",  2'd3, 4'd5,  4'd0,  2, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1);
`endif
      do_op("add_next", 2'd0, 4'd1, 4'd1,  2, 4'd2,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0);

      // MUL 6*7 with start re-pulsed in cycles 1..4
      wait_idle();
      bus.start = 1'b1; bus.op = 2'd2; bus.a = 4'd6; bus.b = 4'd7;
      @(posedge clk); #1;
      pulses = 0;
      done_cyc = 0;
      for (int c = 1; c <= 10; c++) begin
         bus.start = (c <= 4);
         bus.op = 2'($urandom_range(0, 3));
         bus.a = 4'($urandom_range(0, 15));
         bus.b = 4'($urandom_range(0, 15));
         if (bus.done) begin
            pulses++;
            done_cyc = c;
            chk("mul42_prod", {bus.res_hi, bus.res_lo}, 8'd42);
         end
         @(posedge clk); #1;
      end
      chk("mul42_pulses", 8'(pulses), 8'd1);
      chk("mul42_cycle", 8'(done_cyc), 8'd5);

      // Reset asserted in cycle 2 of a MUL
      wait_idle();
      bus.start = 1'b1; bus.op = 2'd2; bus.a = 4'd3; bus.b = 4'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 8'(bus.busy), 8'd0);
      chk("midrst_outs", {bus.done, bus.carry, bus.zf, bus.of, bus.dz, 3'd0}, 8'd0);
      chk("midrst_res", {bus.res_hi, bus.res_lo}, 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_op("mul_after_rst", 2'd2, 4'd3, 4'd5, 5, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random traffic, including starts while busy and frequent b==0
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         bus.start = ($urandom_range(0, 2) == 0);
         bus.op = 2'($urandom_range(0, 3));
         bus.a = 4'($urandom_range(0, 15));
         bus.b = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
